// File: rtl/mem_arbiter_rr_pkg.sv
// Shared definitions for the two-requester round-robin memory arbiter.
// Holds the FSM state encoding, requester ids and default word/address widths.
package mem_arbiter_rr_pkg;

  localparam int unsigned M_DEF = 8;  // data word width
  localparam int unsigned K_DEF = 4;  // address width

  // Requester ids
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle between two requesters, the arbiter and a single-port memory.
// slave  : arbiter view (takes requests and mem_dout, drives acks, read data and mem_*)
// master : requester/memory-side view (drives requests and mem_dout)
interface mem_arbiter_rr_if #(
  parameter int unsigned M = 8,
  parameter int unsigned K = 4
);
  logic         req0;
  logic         we0;
  logic [K-1:0] addr0;
  logic [M-1:0] din0;
  logic         ack0;
  logic [M-1:0] dout0;

  logic         req1;
  logic         we1;
  logic [K-1:0] addr1;
  logic [M-1:0] din1;
  logic         ack1;
  logic [M-1:0] dout1;

  logic         mem_we;
  logic [K-1:0] mem_addr;
  logic [M-1:0] mem_din;
  logic [M-1:0] mem_dout;

  modport slave (
    input  req0, we0, addr0, din0, req1, we1, addr1, din1, mem_dout,
    output ack0, dout0, ack1, dout1, mem_we, mem_addr, mem_din
  );

  modport master (
    output req0, we0, addr0, din0, req1, we1, addr1, din1, mem_dout,
    input  ack0, dout0, ack1, dout1, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/memoryV1.sv
// Single-port memory: synchronous write, combinational read of addr.
// Ports: clk, we (write enable), addr (word address), Min (write data), Mout (read data).
module memoryV1 #(
  parameter int unsigned M = 8,
  parameter int unsigned K = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [K-1:0] addr,
  input  logic [M-1:0] Min,
  output logic [M-1:0] Mout
);
  logic [M-1:0] mem_q [2**K];

  // Storage has no reset; contents survive an arbiter reset
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= Min;
  end

  assign Mout = mem_q[addr];
endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin picker holding the last-granted pointer.
// Ports: clk, reset (sync, active-high), req0/req1 (requests), update (commit the
// current pick into the pointer), g (winner id, combinational), any_req (combinational).
module rr_pick2
  import mem_arbiter_rr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic g,
  output logic any_req
);
  logic last_q, last_d;

  // Lone requester wins outright; on contention the one not served last wins
  always_comb begin
    any_req = req0 | req1;
    g       = (req0 & req1) ? ~last_q : (req1 ? REQ1 : REQ0);
    last_d  = update ? g : last_q;
  end

  // Pointer resets to requester 1 so requester 0 wins the first contention
  always_ff @(posedge clk) begin
    if (reset) last_q <= REQ1;
    else       last_q <= last_d;
  end
endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin controller sharing one single-port memory between two requesters.
// Each access takes IDLE -> ACCESS -> ACK; read data is captured per requester.
// Ports: clk, reset (sync, active-high), bus (slave modport: req/we/addr/din/ack/dout
// per requester plus mem_we/mem_addr/mem_din/mem_dout). All outputs are registered.
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int unsigned M = M_DEF,
  parameter int unsigned K = K_DEF
) (
  input logic              clk,
  input logic              reset,
  mem_arbiter_rr_if.slave  bus
);
  state_e       state_q, state_d;
  logic         sel_q, sel_d;
  logic         ack0_q, ack0_d, ack1_q, ack1_d;
  logic         mem_we_q, mem_we_d;
  logic [K-1:0] mem_addr_q, mem_addr_d;
  logic [M-1:0] mem_din_q, mem_din_d;
  logic [M-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
  logic         g, any_req, update;

  // Pointer advances only when a grant is actually issued
  assign update = (state_q == ST_IDLE) && any_req;

  rr_pick2 u_pick (
    .clk     (clk),
    .reset   (reset),
    .req0    (bus.req0),
    .req1    (bus.req1),
    .update  (update),
    .g       (g),
    .any_req (any_req)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ack0_d     = ack0_q;
    ack1_d     = ack1_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    dout0_d    = dout0_q;
    dout1_d    = dout1_q;
    case (state_q)
      ST_IDLE: begin
        mem_we_d = 1'b0;
        if (any_req) begin
          sel_d = g;
          if (g == REQ1) begin
            mem_addr_d = bus.addr1;
            mem_din_d  = bus.din1;
            mem_we_d   = bus.we1;
          end else begin
            mem_addr_d = bus.addr0;
            mem_din_d  = bus.din0;
            mem_we_d   = bus.we0;
          end
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // mem_addr has been stable all cycle, so mem_dout is the addressed word
        if (!mem_we_q) begin
          if (sel_q == REQ1) dout1_d = bus.mem_dout;
          else               dout0_d = bus.mem_dout;
        end
        mem_we_d = 1'b0;
        if (sel_q == REQ1) ack1_d = 1'b1;
        else               ack0_d = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        mem_we_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= REQ0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      dout0_q    <= '0;
      dout1_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      dout0_q    <= dout0_d;
      dout1_q    <= dout1_d;
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.dout0    = dout0_q;
  assign bus.dout1    = dout1_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr driving a memoryV1 instance. A transaction-timeline model
// (grant edge, access cycle, ack cycle, word store) predicts every output each cycle.
module tb_mem_arbiter_rr;
  localparam int unsigned M = 8;
  localparam int unsigned K = 4;
  localparam int unsigned D = 16;

  logic clk = 1'b0;
  logic reset;
  always #2 clk = ~clk;

  mem_arbiter_rr_if #(.M(M), .K(K)) bus ();

  mem_arbiter_rr #(.M(M), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  memoryV1 #(8, 4) u_mem (
    .clk  (clk),
    .we   (bus.mem_we),
    .addr (bus.mem_addr),
    .Min  (bus.mem_din),
    .Mout (bus.mem_dout)
  );

  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;
  string phase = "init";
  int    mode = 0;           // 0: drop req after ack, 1: hold req, 2: random traffic
  int    obs_ack [2];
  int    obs_q [$];

  // Requester drive mirrors
  bit           rq [2];
  bit           rw [2];
  logic [K-1:0] ra [2];
  logic [M-1:0] rd [2];

  // Reference model
  logic [M-1:0] mm [D];
  bit           mk [D];
  bit           m_last;
  int           m_free;
  bit           m_act;
  int           m_edge;
  bit           m_g, m_we;
  logic [K-1:0] m_addr;
  logic [M-1:0] m_din;
  logic [K-1:0] e_addr;
  logic [M-1:0] e_din;
  logic [M-1:0] e_dout [2];
  bit           e_dk [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s [%s] cyc=%0d observed=%0h expected=%0h", tag, phase, cyc, obs, exp);
  endtask

  task automatic push();
    bus.req0 = rq[0]; bus.we0 = rw[0]; bus.addr0 = ra[0]; bus.din0 = rd[0];
    bus.req1 = rq[1]; bus.we1 = rw[1]; bus.addr1 = ra[1]; bus.din1 = rd[1];
  endtask

  task automatic issue(input int r, input bit we, input logic [K-1:0] a, input logic [M-1:0] d);
    rq[r] = 1'b1; rw[r] = we; ra[r] = a; rd[r] = d;
    push();
  endtask

  task automatic new_tx(input int r);
    issue(r, 1'($urandom_range(0, 1)), K'($urandom_range(0, D - 1)), M'($urandom));
  endtask

  function automatic bit busy();
    return rq[0] | rq[1] | (m_act && (cyc < m_edge + 2));
  endfunction

  // One clock: sample inputs, advance model, compare every output, update requesters
  task automatic step();
    bit s_rst;
    bit s_rq [2];
    bit ex_we;
    bit ex_ack [2];
    bit hit;
    s_rst = reset;
    s_rq[0] = rq[0];
    s_rq[1] = rq[1];
    @(posedge clk);
    #1;
    cyc = cyc + 1;

    hit = m_act && (cyc == m_edge + 1);
    if (hit && m_we) begin
      mm[m_addr] = m_din;
      mk[m_addr] = 1'b1;
    end
    if (s_rst) begin
      m_act = 1'b0; m_last = 1'b1; m_free = cyc + 1;
      e_addr = '0; e_din = '0;
      e_dout[0] = '0; e_dout[1] = '0; e_dk[0] = 1'b1; e_dk[1] = 1'b1;
    end else begin
      if (hit && !m_we) begin
        e_dk[m_g] = mk[m_addr];
        if (mk[m_addr]) e_dout[m_g] = mm[m_addr];
      end
      if (cyc >= m_free && (s_rq[0] || s_rq[1])) begin
        m_g    = (s_rq[0] && s_rq[1]) ? !m_last : s_rq[1];
        m_last = m_g;
        m_act  = 1'b1;
        m_edge = cyc;
        m_free = cyc + 3;
        m_we   = rw[m_g];
        m_addr = ra[m_g];
        m_din  = rd[m_g];
        e_addr = m_addr;
        e_din  = m_din;
      end
    end
    ex_we     = m_act && (cyc == m_edge) && m_we;
    ex_ack[0] = m_act && (cyc == m_edge + 1) && (m_g == 1'b0);
    ex_ack[1] = m_act && (cyc == m_edge + 1) && (m_g == 1'b1);

    chk("mem_we",   32'(bus.mem_we),   32'(ex_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    chk("mem_din",  32'(bus.mem_din),  32'(e_din));
    chk("ack0",     32'(bus.ack0),     32'(ex_ack[0]));
    chk("ack1",     32'(bus.ack1),     32'(ex_ack[1]));
    if (e_dk[0]) chk("dout0", 32'(bus.dout0), 32'(e_dout[0]));
    if (e_dk[1]) chk("dout1", 32'(bus.dout1), 32'(e_dout[1]));

    if (bus.ack0 === 1'b1) begin obs_ack[0] = obs_ack[0] + 1; obs_q.push_back(0); end
    if (bus.ack1 === 1'b1) begin obs_ack[1] = obs_ack[1] + 1; obs_q.push_back(1); end

    for (int r = 0; r < 2; r++) begin
      if (ex_ack[r]) begin
        if (mode == 0) rq[r] = 1'b0;
        else if (mode == 2) begin
          if ($urandom_range(0, 1) == 1) new_tx(r);
          else rq[r] = 1'b0;
        end
      end else if (mode == 2 && !rq[r] && $urandom_range(0, 2) == 0) begin
        new_tx(r);
      end
    end
    push();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n = n + 1;
    end
    chk({tag, "_timeout"}, 32'(busy()), 32'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int a0, a1, first;
    reset = 1'b1;
    for (int r = 0; r < 2; r++) begin
      rq[r] = 1'b0; rw[r] = 1'b0; ra[r] = '0; rd[r] = '0;
      obs_ack[r] = 0; e_dout[r] = '0; e_dk[r] = 1'b1;
    end
    for (int i = 0; i < int'(D); i++) begin mm[i] = '0; mk[i] = 1'b0; end
    m_last = 1'b1; m_free = 0; m_act = 1'b0; m_edge = 0; m_g = 1'b0; m_we = 1'b0;
    m_addr = '0; m_din = '0; e_addr = '0; e_din = '0;
    push();

    // Reset state
    phase = "reset";
    do_reset();
    chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
    chk("rst_dout0",  32'(bus.dout0),  32'(0));
    chk("rst_dout1",  32'(bus.dout1),  32'(0));

    // Single write from requester 0
    phase = "wr0";
    mode = 0;
    a0 = obs_ack[0]; a1 = obs_ack[1];
    issue(0, 1'b1, 4'd7, 8'd127);
    step();
    chk("wr0_mem_we",   32'(bus.mem_we),   32'(1));
    chk("wr0_mem_addr", 32'(bus.mem_addr), 32'(7));
    chk("wr0_mem_din",  32'(bus.mem_din),  32'(127));
    step();
    chk("wr0_ack0_hi",  32'(bus.ack0),     32'(1));
    chk("wr0_we_lo",    32'(bus.mem_we),   32'(0));
    step();
    chk("wr0_ack0_lo",  32'(bus.ack0),     32'(0));
    wait_idle("wr0", 10);
    chk("wr0_ack0_cnt", 32'(obs_ack[0] - a0), 32'(1));
    chk("wr0_ack1_cnt", 32'(obs_ack[1] - a1), 32'(0));

    // Requester 1 write/read back, then requester 0 read back
    phase = "rw1";
    issue(1, 1'b1, 4'd8, 8'd255);
    wait_idle("wr1", 10);
    issue(1, 1'b0, 4'd8, 8'd0);
    wait_idle("rd1", 10);
    chk("rd1_dout1", 32'(bus.dout1), 32'(255));
    issue(0, 1'b0, 4'd7, 8'd0);
    wait_idle("rd0", 10);
    chk("rd0_dout0", 32'(bus.dout0), 32'(127));

    // Simultaneous held reads alternate starting with requester 0
    phase = "contend";
    do_reset();
    mode = 1;
    obs_q.delete();
    issue(0, 1'b0, 4'd7, 8'd0);
    issue(1, 1'b0, 4'd8, 8'd0);
    for (int i = 0; i < 12; i++) step();
    chk("alt_count", 32'(obs_q.size()), 32'(4));
    if (obs_q.size() >= 4) begin
      chk("alt_g0", 32'(obs_q[0]), 32'(0));
      chk("alt_g1", 32'(obs_q[1]), 32'(1));
      chk("alt_g2", 32'(obs_q[2]), 32'(0));
      chk("alt_g3", 32'(obs_q[3]), 32'(1));
    end
    mode = 0;
    wait_idle("alt", 30);
    chk("alt_dout0", 32'(bus.dout0), 32'(127));
    chk("alt_dout1", 32'(bus.dout1), 32'(255));

    // Reset during ACCESS of a write aborts the ack but keeps the write
    phase = "abort";
    a1 = obs_ack[1];
    issue(1, 1'b1, 4'd3, 8'hA5);
    step();
    chk("abort_we_hi", 32'(bus.mem_we), 32'(1));
    rq[1] = 1'b0;
    push();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_we_lo", 32'(bus.mem_we), 32'(0));
    for (int i = 0; i < 4; i++) step();
    chk("abort_no_ack1", 32'(obs_ack[1] - a1), 32'(0));
    issue(0, 1'b0, 4'd3, 8'd0);
    wait_idle("abort_rd", 10);
    chk("abort_kept", 32'(bus.dout0), 32'(8'hA5));

    // Long idle leaves the pointer alone: last grant was 0, so 1 wins now
    phase = "idle";
    a0 = obs_ack[0]; a1 = obs_ack[1];
    for (int i = 0; i < 10; i++) step();
    chk("idle_no_ack", 32'((obs_ack[0] - a0) + (obs_ack[1] - a1)), 32'(0));
    obs_q.delete();
    issue(0, 1'b0, 4'd7, 8'd0);
    issue(1, 1'b0, 4'd8, 8'd0);
    wait_idle("idle_cont", 20);
    first = (obs_q.size() > 0) ? obs_q[0] : -1;
    chk("idle_first", 32'(first), 32'(1));

    // Random traffic against the model
    phase = "random";
    mode = 2;
    for (int i = 0; i < 600; i++) step();
    mode = 0;
    wait_idle("random", 30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
